// File: rtl/palette_ram_stage.sv
// CPU-writable 12-bit colour palette feeding the 4-to-8 bit colour LUTs.
// Two-tick pixel pipeline with matched timing delay and a post-reset clear.
module palette_ram_stage #(
    parameter int IDX_W     = 10,
    parameter bit CLR_START = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [IDX_W-1:0] pix_idx,
    input  logic             hblank_in,
    input  logic             vblank_in,
    input  logic             hs_in,
    input  logic             vs_in,
    output logic [3:0]       r4,
    output logic [3:0]       g4,
    output logic [3:0]       b4,
    output logic             hblank_out,
    output logic             vblank_out,
    output logic             hs_out,
    output logic             vs_out,
    input  logic             cpu_req,
    input  logic             cpu_wr,
    input  logic [IDX_W:0]   cpu_addr,
    input  logic [7:0]       cpu_din,
    output logic [7:0]       cpu_dout,
    output logic             cpu_ack,
    output logic             busy
);

    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_RUN,
        S_ACK
    } state_t;

    state_t state, state_nx;

    logic [IDX_W-1:0] clr_cnt;
    logic [IDX_W-1:0] entry;
    logic             accept;

    // Byte-wide split so each CPU byte write maps to its own RAM
    logic [7:0] ram_rg [DEPTH];
    logic [3:0] ram_b  [DEPTH];

    logic             we_rg;
    logic             we_b;
    logic [IDX_W-1:0] wa;
    logic [7:0]       wd_rg;
    logic [3:0]       wd_b;

    logic [7:0]  pix_rg;
    logic [3:0]  pix_b;
    logic [3:0]  t1;
    logic [3:0]  t2;
    logic [11:0] rgb_q;

    assign entry = cpu_addr[IDX_W:1];

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_CLEAR: if (&clr_cnt) state_nx = S_RUN;
            S_RUN: begin
                if (cpu_req) begin
                    accept   = 1'b1;
                    state_nx = S_ACK;
                end
            end
            S_ACK:   state_nx = S_RUN;
            default: state_nx = S_RUN;
        endcase
    end

    always_comb begin
        we_rg = 1'b0;
        we_b  = 1'b0;
        wa    = entry;
        wd_rg = cpu_din;
        wd_b  = cpu_din[3:0];
        if (!reset) begin
            if (state == S_CLEAR) begin
                we_rg = 1'b1;
                we_b  = 1'b1;
                wa    = clr_cnt;
                wd_rg = 8'h00;
                wd_b  = 4'h0;
            end else if (accept && cpu_wr) begin
                we_rg = ~cpu_addr[0];
                we_b  = cpu_addr[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we_rg) ram_rg[wa] <= wd_rg;
        if (we_b)  ram_b[wa]  <= wd_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLR_START ? S_CLEAR : S_RUN;
            clr_cnt  <= '0;
            cpu_dout <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (accept && !cpu_wr)
                cpu_dout <= cpu_addr[0] ? {4'h0, ram_b[entry]} : ram_rg[entry];
        end
    end

    // Pixel read port: old data wins on a same-cycle CPU write
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_rg <= 8'h00;
            pix_b  <= 4'h0;
        end else if (ce_pix) begin
            pix_rg <= ram_rg[pix_idx];
            pix_b  <= ram_b[pix_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t1    <= 4'h0;
            t2    <= 4'h0;
            rgb_q <= 12'h000;
        end else if (ce_pix) begin
            t1    <= {hblank_in, vblank_in, hs_in, vs_in};
            t2    <= t1;
            rgb_q <= (t1[3] | t1[2]) ? 12'h000 : {pix_rg, pix_b};
        end
    end

    assign busy       = (state == S_CLEAR);
    assign cpu_ack    = (state == S_ACK);
    assign r4         = busy ? 4'h0 : rgb_q[11:8];
    assign g4         = busy ? 4'h0 : rgb_q[7:4];
    assign b4         = busy ? 4'h0 : rgb_q[3:0];
    assign hblank_out = t2[3];
    assign vblank_out = t2[2];
    assign hs_out     = t2[1];
    assign vs_out     = t2[0];

endmodule

// File: tb/tb_palette_ram_stage.sv
// Directed self-checking bench for palette_ram_stage.
// Vector table for CPU accesses plus hand sequences for pipeline corners.
module tb_palette_ram_stage;

    logic        clk;
    logic        reset;
    logic        ce_pix;
    logic [9:0]  pix_idx;
    logic        hblank_in, vblank_in, hs_in, vs_in;
    logic [3:0]  r4, g4, b4;
    logic        hblank_out, vblank_out, hs_out, vs_out;
    logic        cpu_req, cpu_wr;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        busy;

    int tests;
    int fails;

    palette_ram_stage #(.IDX_W(10), .CLR_START(1'b1)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .pix_idx(pix_idx),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .hs_in(hs_in), .vs_in(vs_in),
        .r4(r4), .g4(g4), .b4(b4),
        .hblank_out(hblank_out), .vblank_out(vblank_out),
        .hs_out(hs_out), .vs_out(vs_out),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp;
    } vec_t;

    vec_t vt[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_access(input logic wr, input logic [10:0] addr,
                              input logic [7:0] din, output logic [7:0] dout,
                              output int lat);
        cpu_req  = 1'b1;
        cpu_wr   = wr;
        cpu_addr = addr;
        cpu_din  = din;
        lat      = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 20);
        dout    = cpu_dout;
        cpu_req = 1'b0;
        tick();
        chk("ack one-cycle pulse", {31'd0, cpu_ack}, 32'd0);
    endtask

    task automatic count_busy(output int n, output int acks);
        n    = 0;
        acks = 0;
        while (busy && n < 3000) begin
            n++;
            if (cpu_ack) acks++;
            tick();
        end
    endtask

    initial begin
        logic [7:0] d;
        int         lat;
        int         n;
        int         acks;
        logic       on;

        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        ce_pix    = 1'b0;
        pix_idx   = '0;
        hblank_in = 1'b0;
        vblank_in = 1'b0;
        hs_in     = 1'b0;
        vs_in     = 1'b0;
        cpu_req   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;

        vt[0]  = '{1'b0, 11'h000, 8'h00, 8'h00};
        vt[1]  = '{1'b0, 11'h001, 8'h00, 8'h00};
        vt[2]  = '{1'b0, 11'h7FF, 8'h00, 8'h00};
        vt[3]  = '{1'b0, 11'h00A, 8'h00, 8'h00};
        vt[4]  = '{1'b1, 11'h00A, 8'hA5, 8'h00};
        vt[5]  = '{1'b1, 11'h00B, 8'hF3, 8'h00};
        vt[6]  = '{1'b0, 11'h00B, 8'h00, 8'h03};
        vt[7]  = '{1'b0, 11'h00A, 8'h00, 8'hA5};
        vt[8]  = '{1'b1, 11'h00E, 8'h12, 8'h00};
        vt[9]  = '{1'b1, 11'h00F, 8'hF4, 8'h00};
        vt[10] = '{1'b0, 11'h00F, 8'h00, 8'h04};
        vt[11] = '{1'b0, 11'h00E, 8'h00, 8'h12};

        repeat (3) tick();
        chk("reset r4g4b4", {20'd0, r4, g4, b4}, 32'd0);
        chk("reset timing", {28'd0, hblank_out, vblank_out, hs_out, vs_out}, 32'd0);
        chk("reset cpu_dout", {24'd0, cpu_dout}, 32'd0);
        chk("reset cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd1);

        reset = 1'b0;
        count_busy(n, acks);
        chk("clear length", n, 1024);
        chk("busy low after clear", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            cpu_access(vt[i].wr, vt[i].addr, vt[i].din, d, lat);
            chk("ack latency", lat, 1);
            if (!vt[i].wr) chk("cpu read data", {24'd0, d}, {24'd0, vt[i].exp});
        end

        // Steady ce_pix: colour 5 two ticks after presentation
        ce_pix  = 1'b1;
        pix_idx = 10'd0;
        repeat (3) tick();
        pix_idx = 10'd5;
        tick();
        pix_idx = 10'd0;
        chk("pix tick1 still old", {20'd0, r4, g4, b4}, 32'h000);
        tick();
        chk("pix colour 5", {20'd0, r4, g4, b4}, 32'hA53);
        tick();
        chk("pix back to 0", {20'd0, r4, g4, b4}, 32'h000);

        // ce_pix every 4th clk, hs pulse aligned with index 5
        for (int c = 0; c < 12; c++) begin
            ce_pix  = (c % 4 == 0);
            pix_idx = (c < 4) ? 10'd5 : 10'd0;
            hs_in   = (c < 4);
            tick();
            on = (c >= 4 && c < 8);
            chk("sparse ce hs/colour",
                {19'd0, hs_out, r4, g4, b4},
                on ? 32'h1A53 : 32'h0000);
        end
        hs_in = 1'b0;

        // Blanking gates colour but passes through
        ce_pix    = 1'b1;
        pix_idx   = 10'd5;
        hblank_in = 1'b1;
        tick();
        hblank_in = 1'b0;
        tick();
        chk("hblank gated colour", {19'd0, hblank_out, r4, g4, b4}, 32'h1000);
        tick();
        chk("after hblank colour", {19'd0, hblank_out, r4, g4, b4}, 32'h0A53);

        // Same-cycle CPU write and pixel read of entry 7
        pix_idx  = 10'd7;
        cpu_req  = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = 11'h00E;
        cpu_din  = 8'h9C;
        tick();
        chk("collision ack", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
        tick();
        chk("collision old colour", {20'd0, r4, g4, b4}, 32'h124);
        tick();
        chk("collision new colour", {20'd0, r4, g4, b4}, 32'h9C4);

        // Reset mid-sweep with a pending read request
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acks  = 0;
        for (int k = 0; k < 300; k++) begin
            if (k == 290) begin
                cpu_req  = 1'b1;
                cpu_wr   = 1'b0;
                cpu_addr = 11'h00E;
            end
            if (cpu_ack) acks++;
            tick();
        end
        chk("busy at cnt 300", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset mid-sweep ack", {31'd0, cpu_ack}, 32'd0);
        count_busy(n, lat);
        acks += lat;
        chk("restarted clear length", n, 1024);
        chk("no ack while busy", acks, 0);
        lat = 0;
        while (!cpu_ack && lat < 20) begin
            tick();
            lat++;
        end
        chk("held req acked", lat, 1);
        chk("held req data cleared", {24'd0, cpu_dout}, 32'd0);
        cpu_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
